// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter and its transfer controller.
// Used by rr_onehot_enc and rr_grant_xfer_ctrl (optional macro: XFER_TIMEOUT_EN).
package rr_arb_pkg;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned TIMEOUT_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // OR-reduction of set-bit positions; only meaningful for a one-hot input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & (v - one)) == '0);
  endfunction

endpackage

// File: rtl/rr_onehot_enc.sv
// Grant-vector encoder: index of the set bit plus any/one-hot qualifiers.
module rr_onehot_enc
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any,
  output logic             o_onehot
);

  // Pure combinational decode of the grant vector.
  always_comb begin
    o_idx    = onehot_to_idx(i_vec);
    o_any    = |i_vec;
    o_onehot = is_onehot(i_vec);
  end

endmodule

// File: rtl/rr_grant_xfer_ctrl.sv
// Burst transfer controller behind a one-hot round-robin grant.
// Latches the granted master, streams len+1 beats to the sink, then pulses done.
// err is registered: it pulses the cycle after an illegal grant is seen in IDLE.
// Optional macro XFER_TIMEOUT_EN adds an 8-bit stall timeout that ends the burst early.
module rr_grant_xfer_ctrl
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned LW = 4,
  parameter int unsigned OW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_grant,
  input  logic [N-1:0]  i_req,
  input  logic [N*DW-1:0] i_m_data,
  input  logic [N*LW-1:0] i_m_len,
  input  logic          i_s_ready,
  output logic          o_s_valid,
  output logic [DW-1:0] o_s_data,
  output logic          o_s_last,
  output logic [OW-1:0] o_owner,
  output logic          o_busy,
  output logic [N-1:0]  o_hold,
  output logic [N-1:0]  o_done,
  output logic          o_err
);

  state_e        r_state, w_state_d;
  logic [OW-1:0] r_owner, w_owner_d;
  logic [LW-1:0] r_len,   w_len_d;
  logic [LW-1:0] r_cnt,   w_cnt_d;
  logic          r_err,   w_err_d;
`ifdef XFER_TIMEOUT_EN
  logic [7:0]    r_stall, w_stall_d;
`endif

  logic [OW-1:0] w_idx;
  logic          w_any;
  logic          w_onehot;
  logic [DW-1:0] w_data_arr [N];
  logic [LW-1:0] w_len_arr  [N];
  logic          w_last;
  logic [N-1:0]  w_owner_oh;

  rr_onehot_enc u_enc (
    .i_vec    (i_grant),
    .o_idx    (w_idx),
    .o_any    (w_any),
    .o_onehot (w_onehot)
  );

  // Unpack the flat per-master buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_data_arr[i] = i_m_data[i*DW +: DW];
      w_len_arr[i]  = i_m_len[i*LW +: LW];
    end
  end

  always_comb begin
    w_last     = (r_state == XFER) && (r_cnt == r_len);
    w_owner_oh = N'(1) << r_owner;
  end

  // Next-state logic; grant/req are only looked at in IDLE so a burst always completes.
  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_len_d   = r_len;
    w_cnt_d   = r_cnt;
    w_err_d   = 1'b0;
`ifdef XFER_TIMEOUT_EN
    w_stall_d = r_stall;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_onehot && i_req[w_idx]) begin
          w_owner_d = w_idx;
          w_len_d   = w_len_arr[w_idx];
          w_cnt_d   = '0;
          w_state_d = XFER;
`ifdef XFER_TIMEOUT_EN
          w_stall_d = '0;
`endif
        end else if (w_any && !w_onehot) begin
          w_err_d = 1'b1;
        end
      end
      XFER: begin
        if (i_s_ready) begin
`ifdef XFER_TIMEOUT_EN
          w_stall_d = '0;
`endif
          // Exit on equality, so the counter never wraps even at len = 2^LW-1.
          if (w_last) w_state_d = DONE;
          else        w_cnt_d   = r_cnt + 1'b1;
        end else begin
`ifdef XFER_TIMEOUT_EN
          // 255th consecutive stall cycle: abandon the burst with an error.
          if (r_stall == 8'(TIMEOUT_MAX - 1)) begin
            w_state_d = DONE;
            w_err_d   = 1'b1;
          end else begin
            w_stall_d = r_stall + 8'd1;
          end
`endif
        end
      end
      DONE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
`ifdef XFER_TIMEOUT_EN
      r_stall <= '0;
`endif
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_len   <= w_len_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
`ifdef XFER_TIMEOUT_EN
      r_stall <= w_stall_d;
`endif
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_s_valid = (r_state == XFER);
    o_s_data  = w_data_arr[r_owner];
    o_s_last  = w_last;
    o_owner   = r_owner;
    o_busy    = (r_state != IDLE);
    o_hold    = (r_state != IDLE) ? w_owner_oh : '0;
    o_done    = (r_state == DONE) ? w_owner_oh : '0;
    o_err     = r_err;
  end

endmodule

// File: tb/tb_rr_grant_xfer_ctrl.sv
// Self-checking bench for rr_grant_xfer_ctrl; follows XFER_TIMEOUT_EN if defined.
// Expectations come from a burst-level model: len+1 accepted beats, last on the final one,
// done one cycle after, then one idle cycle.
module tb_rr_grant_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  grant, req;
  logic [31:0] m_data;
  logic [15:0] m_len;
  logic        s_ready;
  logic        s_valid, s_last, busy, err;
  logic [7:0]  s_data;
  logic [1:0]  owner;
  logic [3:0]  hold, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rr_grant_xfer_ctrl dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_grant   (grant),
    .i_req     (req),
    .i_m_data  (m_data),
    .i_m_len   (m_len),
    .i_s_ready (s_ready),
    .o_s_valid (s_valid),
    .o_s_data  (s_data),
    .o_s_last  (s_last),
    .o_owner   (owner),
    .o_busy    (busy),
    .o_hold    (hold),
    .o_done    (done),
    .o_err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] data_of(input int idx);
    return m_data[idx*8 +: 8];
  endfunction

  // One burst from IDLE. Ready follows rpat bits when use_pat, else rpct percent.
  // mid_grant is driven on grant/req during XFER; keep leaves it there after DONE.
  task automatic do_burst(input int idx, input int len, input int rpct, input bit use_pat,
                          input logic [31:0] rpat, input logic [3:0] mid_grant, input bit keep);
    logic [3:0] oh;
    int acc;
    int cyc;
    oh  = 4'(1 << idx);
    acc = 0;
    cyc = 0;
    m_len[idx*4 +: 4] = 4'(len);
    m_data  = $urandom;
    grant   = oh;
    req     = oh;
    s_ready = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(s_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    step();
    grant = mid_grant;
    req   = mid_grant;
    while (acc <= len && cyc < 300) begin
      s_ready = use_pat ? rpat[cyc % 32] : ($urandom_range(99) < 32'(rpct));
      m_data  = $urandom;
      @(negedge clk);
      chk("xfer_valid", 32'(s_valid), 1);
      chk("xfer_data", 32'(s_data), 32'(data_of(idx)));
      chk("xfer_last", 32'(s_last), 32'(acc == len));
      chk("xfer_owner", 32'(owner), 32'(idx));
      chk("xfer_hold", 32'(hold), 32'(oh));
      chk("xfer_done", 32'(done), 0);
      chk("xfer_err", 32'(err), 0);
      if (s_ready) acc++;
      step();
      cyc++;
    end
    chk("beats", 32'(acc), 32'(len + 1));
    s_ready = 1'b0;
    if (!keep) begin
      grant = '0;
      req   = '0;
    end
    @(negedge clk);
    chk("done_vec", 32'(done), 32'(oh));
    chk("done_valid", 32'(s_valid), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_hold", 32'(hold), 32'(oh));
    step();
    @(negedge clk);
    chk("gap_busy", 32'(busy), 0);
    chk("gap_done", 32'(done), 0);
    chk("gap_hold", 32'(hold), 0);
    step();
  endtask

  // Drive ready high until done appears, with a cycle bound.
  task automatic drain(input logic [3:0] exp_done);
    int k;
    k = 0;
    grant   = '0;
    req     = '0;
    s_ready = 1'b1;
    @(negedge clk);
    while (done == '0 && k < 40) begin
      step();
      @(negedge clk);
      k++;
    end
    chk("drain_done", 32'(done), 32'(exp_done));
    s_ready = 1'b0;
    step();
    step();
  endtask

  initial begin
    int stalls;
    rst     = 1'b1;
    grant   = '0;
    req     = '0;
    m_data  = '0;
    m_len   = '0;
    s_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_hold", 32'(hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    step();
    rst = 1'b0;
    step();

    // Single burst, master 1, 3 beats, always ready.
    do_burst(1, 2, 100, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    // Backpressure, master 2, 2 beats, ready 1,0,0,1.
    do_burst(2, 1, 0, 1'b1, 32'h0000_0009, 4'b0000, 1'b0);
    // Max length burst: 16 beats.
    do_burst(0, 15, 100, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0);

    // Grant moves to master 0 mid-burst; master 0 starts only after DONE + 1 idle cycle.
    m_len[3:0] = 4'd1;
    do_burst(3, 3, 100, 1'b1, 32'hFFFF_FFFF, 4'b0001, 1'b1);
    @(negedge clk);
    chk("next_owner", 32'(owner), 0);
    chk("next_valid", 32'(s_valid), 1);
    drain(4'b0001);

    // Illegal grant in IDLE.
    grant = 4'b0011;
    req   = 4'b0011;
    @(negedge clk);
    chk("ill_err_pre", 32'(err), 0);
    step();
    grant = '0;
    req   = '0;
    @(negedge clk);
    chk("ill_err", 32'(err), 1);
    chk("ill_busy", 32'(busy), 0);
    chk("ill_valid", 32'(s_valid), 0);
    step();
    @(negedge clk);
    chk("ill_err_clr", 32'(err), 0);
    step();

    // Reset on beat 2 of a 4-beat burst.
    m_len[11:8] = 4'd3;
    grant   = 4'b0100;
    req     = 4'b0100;
    s_ready = 1'b1;
    step();
    grant = '0;
    req   = '0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rb_valid", 32'(s_valid), 1);
    chk("rb_last", 32'(s_last), 0);
    step();
    rst     = 1'b0;
    s_ready = 1'b0;
    @(negedge clk);
    chk("ra_valid", 32'(s_valid), 0);
    chk("ra_busy", 32'(busy), 0);
    chk("ra_hold", 32'(hold), 0);
    chk("ra_done", 32'(done), 0);
    chk("ra_owner", 32'(owner), 0);
    step();
    @(negedge clk);
    chk("ra_done2", 32'(done), 0);
    step();

    // Stall with ready held low on master 3.
    m_len[15:12] = 4'd2;
    grant = 4'b1000;
    req   = 4'b1000;
    step();
    grant  = '0;
    req    = '0;
    stalls = 0;
    @(negedge clk);
    while (done == '0 && stalls < 400) begin
      stalls++;
      step();
      @(negedge clk);
    end
`ifdef XFER_TIMEOUT_EN
    chk("to_stalls", 32'(stalls), 255);
    chk("to_done", 32'(done), 32'h8);
    chk("to_err", 32'(err), 1);
    step();
    step();
`else
    chk("nto_busy", 32'(busy), 1);
    chk("nto_valid", 32'(s_valid), 1);
    chk("nto_done", 32'(done), 0);
    step();
    drain(4'b1000);
`endif

    // Randomized bursts with random mid-burst grant/req noise.
    for (int t = 0; t < 20; t++) begin
      do_burst($urandom_range(3), $urandom_range(15), $urandom_range(100, 30), 1'b0, 32'h0,
               4'($urandom_range(15)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
